// File: rtl/voice_mixer.sv
// N-voice sample mixer: captures the active voices on a strobe and emits either
// their floor average (serial restoring divider) or their saturated sum.
module voice_mixer #(
    parameter int NUM_VOICES = 13,
    parameter int SAMPLE_W   = 8
) (
    input  logic                           clk,
    input  logic                           nRst,
    input  logic                           en,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] samples,
    input  logic [NUM_VOICES-1:0]          active,
    input  logic                           mode,
    output logic [SAMPLE_W-1:0]            mixed_sample,
    output logic                           valid,
    output logic                           busy,
    output logic                           overrun
);

    localparam int CNT_W  = $clog2(NUM_VOICES + 1);
    localparam int SUM_W  = SAMPLE_W + CNT_W;
    localparam int ITER_W = $clog2(SUM_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SUM_W-1:0]    r_sum;
    logic [SUM_W-1:0]    r_sum_orig;
    logic [CNT_W-1:0]    r_rem;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_mode;
    logic [ITER_W-1:0]   r_iter;
    logic [SAMPLE_W-1:0] r_mixed;
    logic                r_valid;
    logic                r_busy;
    logic                r_overrun;

    logic [SUM_W-1:0]    w_sum_in;
    logic [CNT_W-1:0]    w_cnt_in;
    logic [CNT_W:0]      w_rem_sh;
    logic                w_qbit;
    logic [CNT_W-1:0]    w_rem_nxt;
    logic [SAMPLE_W-1:0] w_result;

    // Clamp a full-width sum to the largest representable output sample.
    function automatic logic [SAMPLE_W-1:0] saturate(input logic [SUM_W-1:0] value);
        logic [SAMPLE_W-1:0] result;
        if (|value[SUM_W-1:SAMPLE_W]) begin
            result = '1;
        end else begin
            result = value[SAMPLE_W-1:0];
        end
        return result;
    endfunction

    // Sum and population count of the active voices, sampled on acceptance.
    always_comb begin
        w_sum_in = '0;
        w_cnt_in = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_sum_in = w_sum_in + (active[i] ? SUM_W'(samples[i*SAMPLE_W +: SAMPLE_W]) : SUM_W'(1'b0));
            w_cnt_in = w_cnt_in + (active[i] ? CNT_W'(1'b1) : CNT_W'(1'b0));
        end
    end

    // One restoring-division step; remainder stays below the divisor so CNT_W bits suffice.
    always_comb begin
        w_rem_sh = {r_rem, r_sum[SUM_W-1]};
        w_qbit   = (w_rem_sh >= {1'b0, r_cnt});
        if (w_qbit) begin
            w_rem_nxt = CNT_W'(w_rem_sh - {1'b0, r_cnt});
        end else begin
            w_rem_nxt = w_rem_sh[CNT_W-1:0];
        end
    end

    // Output selection at completion; a zero divisor yields 0 in average mode.
    always_comb begin
        if (r_mode) begin
            w_result = saturate(r_sum_orig);
        end else if (r_cnt == '0) begin
            w_result = '0;
        end else begin
            w_result = r_sum[SAMPLE_W-1:0];
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (en) begin
                    w_state_nxt = DIV;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            DIV: begin
                if (r_iter == ITER_W'(1'b1)) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = DIV;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            r_sum      <= '0;
            r_sum_orig <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_mode     <= 1'b0;
            r_iter     <= '0;
            r_mixed    <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != IDLE);
            case (r_state)
                IDLE: begin
                    r_valid   <= 1'b0;
                    r_overrun <= 1'b0;
                    if (en) begin
                        r_sum      <= w_sum_in;
                        r_sum_orig <= w_sum_in;
                        r_cnt      <= w_cnt_in;
                        r_mode     <= mode;
                        r_rem      <= '0;
                        r_iter     <= ITER_W'(SUM_W);
                    end
                end
                DIV: begin
                    r_valid   <= 1'b0;
                    r_overrun <= en;
                    r_sum     <= {r_sum[SUM_W-2:0], w_qbit};
                    r_rem     <= w_rem_nxt;
                    r_iter    <= r_iter - ITER_W'(1'b1);
                end
                DONE: begin
                    r_mixed   <= w_result;
                    r_valid   <= 1'b1;
                    r_overrun <= en;
                end
                default: begin
                    r_valid   <= 1'b0;
                    r_overrun <= 1'b0;
                end
            endcase
        end
    end

    assign mixed_sample = r_mixed;
    assign valid        = r_valid;
    assign busy         = r_busy;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_voice_mixer.sv
// Self-checking bench for voice_mixer: directed vector table, hand-written
// overrun/reset/back-to-back sequences and randomized mixes vs. an arithmetic model.
module tb_voice_mixer;

    localparam int NV  = 13;
    localparam int SW  = 8;
    localparam int LAT = 13;          // SUM_W + 1 at defaults (SUM_W = 12)
    localparam int NV2 = 4;
    localparam int SW2 = 12;
    localparam int LAT2 = 16;         // SUM_W = 12 + 3 = 15

    logic              clk = 1'b0;
    logic              nRst;
    logic              en;
    logic [NV*SW-1:0]  samples;
    logic [NV-1:0]     active;
    logic              mode;
    logic [SW-1:0]     mixed_sample;
    logic              valid, busy, overrun;

    logic               en2;
    logic [NV2*SW2-1:0] samples2;
    logic [NV2-1:0]     active2;
    logic               mode2;
    logic [SW2-1:0]     mixed_sample2;
    logic               valid2, busy2, overrun2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    voice_mixer dut (
        .clk(clk), .nRst(nRst), .en(en), .samples(samples), .active(active), .mode(mode),
        .mixed_sample(mixed_sample), .valid(valid), .busy(busy), .overrun(overrun)
    );

    voice_mixer #(.NUM_VOICES(NV2), .SAMPLE_W(SW2)) dut2 (
        .clk(clk), .nRst(nRst), .en(en2), .samples(samples2), .active(active2), .mode(mode2),
        .mixed_sample(mixed_sample2), .valid(valid2), .busy(busy2), .overrun(overrun2)
    );

    typedef struct {
        logic [NV*SW-1:0] smp;
        logic [NV-1:0]    act;
        logic             md;
        logic [SW-1:0]    exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [NV*SW-1:0] fill(input logic [SW-1:0] v);
        logic [NV*SW-1:0] r;
        for (int i = 0; i < NV; i++) r[i*SW +: SW] = v;
        return r;
    endfunction

    // Reference: average or saturated sum straight from the definition.
    function automatic int ref_mix(input logic [NV*SW-1:0] s, input logic [NV-1:0] a, input logic m);
        int sum = 0;
        int cnt = 0;
        for (int i = 0; i < NV; i++) begin
            if (a[i]) begin
                sum += int'(s[i*SW +: SW]);
                cnt++;
            end
        end
        if (m) return (sum > 255) ? 255 : sum;
        if (cnt == 0) return 0;
        return sum / cnt;
    endfunction

    // Starts at a negedge; returns at the negedge where valid is seen (or timeout).
    task automatic mix(input logic [NV*SW-1:0] s, input logic [NV-1:0] a, input logic m,
                       input logic chg, output logic [SW-1:0] res, output int lat,
                       output int busy_cnt);
        samples = s; active = a; mode = m; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        lat = 0;
        busy_cnt = busy ? 1 : 0;
        if (chg) begin
            for (int i = 0; i < NV; i++) samples[i*SW +: SW] = SW'($urandom_range(0, 255));
            active = ~a;
            mode = ~m;
        end
        while (!valid && lat < 40) begin
            @(negedge clk);
            lat++;
            if (busy) busy_cnt++;
        end
        res = mixed_sample;
    endtask

    vec_t             tbl[8];
    logic [NV*SW-1:0] s;
    logic [NV-1:0]    a;
    logic             m;
    logic [SW-1:0]    res;
    int               lat, bcnt, ov_cnt, v_cnt, v_k, busy_late, vseen;
    logic [31:0]      ov_mask;

    initial begin
        nRst = 1'b0; en = 1'b0; samples = '0; active = '0; mode = 1'b0;
        en2 = 1'b0; samples2 = '0; active2 = '0; mode2 = 1'b0;

        s = fill(8'd77); s[7:0] = 8'd100; s[15:8] = 8'd200;
        tbl[1] = '{s, 13'h0003, 1'b0, 8'd150};
        s = fill(8'd0); s[7:0] = 8'd3; s[15:8] = 8'd3; s[23:16] = 8'd4;
        tbl[2] = '{s, 13'h0007, 1'b0, 8'd3};
        s = fill(8'd9); s[7:0] = 8'd200; s[15:8] = 8'd100;
        tbl[3] = '{s, 13'h0000, 1'b0, 8'd0};
        tbl[4] = '{s, 13'h0003, 1'b1, 8'd255};
        s[7:0] = 8'd40; s[15:8] = 8'd50;
        tbl[5] = '{s, 13'h0003, 1'b1, 8'd90};
        tbl[0] = '{fill(8'd255), 13'h1FFF, 1'b0, 8'd255};
        tbl[6] = '{fill(8'd255), 13'h1FFF, 1'b1, 8'd255};
        s = fill(8'd1); s[47:40] = 8'd17;
        tbl[7] = '{s, 13'h0020, 1'b0, 8'd17};

        repeat (3) @(negedge clk);
        chk("rst_mixed", 32'(mixed_sample), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        nRst = 1'b1;
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            mix(tbl[i].smp, tbl[i].act, tbl[i].md, 1'b0, res, lat, bcnt);
            chk($sformatf("vec%0d_result", i), 32'(res), 32'(tbl[i].exp));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
            if (i == 0) chk("vec0_busy_cycles", 32'(bcnt), 32'(LAT));
            @(negedge clk);
            chk($sformatf("vec%0d_valid_pulse", i), 32'(valid), 32'd0);
        end

        // Overrun at cycle 3 and in the DONE cycle (12); the second strobe is dropped
        s = fill(8'd0); s[7:0] = 8'd10; s[15:8] = 8'd20;
        samples = s; active = 13'h0003; mode = 1'b0; en = 1'b1;
        @(negedge clk);
        en = 1'b0; ov_cnt = 0; v_cnt = 0; v_k = -1; ov_mask = '0; busy_late = 1;
        for (int k = 0; k < 16; k++) begin
            if (overrun) begin ov_cnt++; ov_mask[k] = 1'b1; end
            if (valid) begin v_cnt++; v_k = k; res = mixed_sample; end
            if (k == 15) busy_late = int'(busy);
            en = (k == 3 || k == 12);
            @(negedge clk);
        end
        en = 1'b0;
        chk("ovr_count", 32'(ov_cnt), 32'd2);
        chk("ovr_cycles", ov_mask, 32'h0000_2010);
        chk("ovr_valid_count", 32'(v_cnt), 32'd1);
        chk("ovr_valid_cycle", 32'(v_k), 32'(LAT));
        chk("ovr_result", 32'(res), 32'd15);
        chk("ovr_dropped_busy", 32'(busy_late), 32'd0);

        // Back-to-back: second en in the cycle right after valid
        mix(fill(8'd60), 13'h1FFF, 1'b0, 1'b0, res, lat, bcnt);
        chk("b2b_first", 32'(res), 32'd60);
        s = fill(8'd0); s[7:0] = 8'd7; s[15:8] = 8'd8;
        mix(s, 13'h0003, 1'b1, 1'b0, res, lat, bcnt);
        chk("b2b_second", 32'(res), 32'd15);
        chk("b2b_latency", 32'(lat), 32'(LAT));
        @(negedge clk);

        // Input change during DIV is ignored
        s = fill(8'd0); s[7:0] = 8'd50; s[15:8] = 8'd51; s[23:16] = 8'd53;
        mix(s, 13'h0007, 1'b0, 1'b1, res, lat, bcnt);
        chk("chg_result", 32'(res), 32'd51);
        @(negedge clk);

        // Reset during DIV aborts the mix
        samples = fill(8'd200); active = 13'h1FFF; mode = 1'b0; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);
        nRst = 1'b0;
        @(negedge clk);
        chk("abort_mixed", 32'(mixed_sample), 32'd0);
        chk("abort_valid", 32'(valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_overrun", 32'(overrun), 32'd0);
        nRst = 1'b1;
        vseen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (valid) vseen++;
        end
        chk("abort_no_valid", 32'(vseen), 32'd0);
        mix(tbl[1].smp, tbl[1].act, 1'b0, 1'b0, res, lat, bcnt);
        chk("post_abort_result", 32'(res), 32'd150);
        chk("post_abort_latency", 32'(lat), 32'(LAT));
        @(negedge clk);

        // Randomized mixes against the reference model
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < NV; i++) s[i*SW +: SW] = SW'($urandom_range(0, 255));
            a = NV'($urandom_range(0, 8191));
            if (n % 7 == 0) a = '0;
            m = 1'($urandom_range(0, 1));
            mix(s, a, m, 1'($urandom_range(0, 1)), res, lat, bcnt);
            chk($sformatf("rand%0d_result", n), 32'(res), 32'(ref_mix(s, a, m)));
            chk($sformatf("rand%0d_latency", n), 32'(lat), 32'(LAT));
            @(negedge clk);
        end

        // Second configuration: 4 voices x 12 bits
        for (int c = 0; c < 3; c++) begin
            samples2 = {4{12'hFFF}};
            active2  = 4'hF;
            mode2    = (c == 1);
            if (c == 2) begin samples2[11:0] = 12'd1; active2 = 4'h7; end
            en2 = 1'b1;
            @(negedge clk);
            en2 = 1'b0;
            lat = 0;
            while (!valid2 && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            chk($sformatf("cfg2_%0d_result", c), 32'(mixed_sample2),
                (c == 2) ? 32'd2730 : 32'd4095);
            chk($sformatf("cfg2_%0d_latency", c), 32'(lat), 32'(LAT2));
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
